imem_load_ctrl: RTL and testbench

Sequencing controller for the 1024 x 37-bit instruction memory. It owns the memory's single address port and shares it between a program-load stream, which writes sequential words from a base address, and the fetch stage, which reads instructions. Fetch is stalled while a load is in progress. The block sits between the loader/test interface, the fetch stage and the memory. The instruction memory is extended with a synchronous write port (we, wdata) as part of this change.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_load_ctrl.sv | 133 +++++++++++++
 tb/tb_imem_load_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared widths, NOP word and controller state encoding
package imem_pkg;

  localparam int INSTR_W = 37;
  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 1 << ADDR_W;

  localparam logic [INSTR_W-1:0] NOP     = '0;
  localparam logic [ADDR_W:0]    DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  // Requested load length saturated to the memory size.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] len);
    return (len > DEPTH_L) ? DEPTH_L : len;
  endfunction

endpackage

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - arbitrates the instruction memory port between program load and fetch
module imem_load_ctrl
  import imem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic [ADDR_W-1:0]  load_base,
  input  logic [ADDR_W:0]    load_len,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ready,
  output logic               load_done,
  output logic               busy,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_valid,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic               fetch_stall,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] ONE_L = (ADDR_W+1)'(1);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]      remaining_q, remaining_d;
  logic                 fetch_valid_q;
  logic [INSTR_W-1:0]   fetch_instr_q;

  logic                 start_fire;
  logic                 accept;
  logic                 fetch_fire;
  logic [ADDR_W:0]      start_len;

  assign start_len  = clamp_len(load_len);
  assign start_fire = (state_q == RUN) && load_start;
  assign accept     = (state_q == LOAD) && load_valid;
  assign fetch_fire = (state_q == RUN) && fetch_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (load_start) begin
          state_d = (start_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept && (remaining_q == ONE_L)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    load_ready  = 1'b0;
    load_done   = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = fetch_addr;
    mem_wdata   = NOP;
    fetch_stall = 1'b0;
    case (state_q)
      LOAD: begin
        load_ready  = 1'b1;
        mem_addr    = wr_addr_q;
        mem_wdata   = load_data;
        mem_we      = load_valid;
        fetch_stall = fetch_req;
      end
      DONE: begin
        load_done   = 1'b1;
        fetch_stall = fetch_req;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != RUN);

  // Write pointer wraps naturally at the address width.
  always_comb begin
    wr_addr_d   = wr_addr_q;
    remaining_d = remaining_q;
    if (start_fire) begin
      wr_addr_d   = load_base;
      remaining_d = start_len;
    end else if (accept) begin
      wr_addr_d   = wr_addr_q + 1'b1;
      remaining_d = remaining_q - ONE_L;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q   <= '0;
      remaining_q <= '0;
    end else begin
      wr_addr_q   <= wr_addr_d;
      remaining_q <= remaining_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= NOP;
    end else begin
      fetch_valid_q <= fetch_fire;
      if (fetch_fire) begin
        fetch_instr_q <= mem_rdata;
      end
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = fetch_instr_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - randomized self-checking bench with array memory and shadow model
module tb_imem_load_ctrl;
  import imem_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               load_start = 1'b0;
  logic [ADDR_W-1:0]  load_base = '0;
  logic [ADDR_W:0]    load_len = '0;
  logic               load_valid = 1'b0;
  logic [INSTR_W-1:0] load_data = '0;
  logic               load_ready, load_done, busy;
  logic               fetch_req = 1'b0;
  logic [ADDR_W-1:0]  fetch_addr = '0;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_instr;
  logic               fetch_stall;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_we;
  logic [INSTR_W-1:0] mem_wdata;
  logic [INSTR_W-1:0] mem_rdata;

  logic [INSTR_W-1:0] mem     [DEPTH];
  logic [INSTR_W-1:0] ref_mem [DEPTH];
  int                 wcount = 0;
  int                 checks = 0;
  int                 errors = 0;

  imem_load_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_base(load_base), .load_len(load_len),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_done(load_done), .busy(busy),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr), .fetch_stall(fetch_stall),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_wdata;
      wcount <= wcount + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_chk(input logic [ADDR_W-1:0] a, input string tag);
    fetch_req  = 1'b1;
    fetch_addr = a;
    #1;
    chk({tag, "_stall"}, 64'(fetch_stall), 64'(0));
    tick();
    fetch_req = 1'b0;
    chk({tag, "_valid"}, 64'(fetch_valid), 64'(1));
    chk({tag, "_instr"}, 64'(fetch_instr), 64'(ref_mem[a]));
  endtask

  // Model: word k of a load goes to (base + k) mod DEPTH, for k below min(len, DEPTH).
  task automatic do_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] len,
                         input int gap_mode, input bit hold, input bit seq_data);
    int n, k, iter, wbefore;
    logic [ADDR_W-1:0] fa;
    logic [ADDR_W-1:0] wa;
    n  = (int'(len) > DEPTH) ? DEPTH : int'(len);
    fa = ADDR_W'($urandom);
    load_start = 1'b1;
    load_base  = base;
    load_len   = len;
    fetch_req  = hold;
    fetch_addr = fa;
    #1;
    chk("run_stall", 64'(fetch_stall), 64'(0));
    chk("run_busy", 64'(busy), 64'(0));
    wbefore = wcount;
    tick();
    load_start = 1'b0;
    if (hold) begin
      chk("start_fetch_valid", 64'(fetch_valid), 64'(1));
      chk("start_fetch_instr", 64'(fetch_instr), 64'(ref_mem[fa]));
    end
    k = 0;
    iter = 0;
    while (k < n && iter < 5000) begin
      case (gap_mode)
        0:       load_valid = 1'b1;
        1:       load_valid = (iter % 2) == 0;
        default: load_valid = 1'($urandom_range(0, 1));
      endcase
      load_data = seq_data ? INSTR_W'(k + 1) : INSTR_W'({$urandom(), $urandom()});
      if (gap_mode == 2) begin
        load_start = ($urandom_range(0, 3) == 0);
        load_base  = ADDR_W'($urandom);
        load_len   = (ADDR_W+1)'($urandom_range(0, 20));
      end
      #1;
      chk("ld_ready", 64'(load_ready), 64'(1));
      chk("ld_we", 64'(mem_we), 64'(load_valid));
      chk("ld_busy", 64'(busy), 64'(1));
      chk("ld_done_early", 64'(load_done), 64'(0));
      chk("ld_stall", 64'(fetch_stall), 64'(hold));
      if (load_valid) begin
        wa = base + ADDR_W'(k);
        chk("ld_addr", 64'(mem_addr), 64'(wa));
        ref_mem[wa] = load_data;
        k++;
      end
      tick();
      iter++;
      if (hold) chk("ld_no_fetch", 64'(fetch_valid), 64'(0));
    end
    chk("ld_words", 64'(k), 64'(n));
    load_start = 1'b0;
    load_valid = 1'b1;
    #1;
    chk("done_pulse", 64'(load_done), 64'(1));
    chk("done_ready", 64'(load_ready), 64'(0));
    chk("done_we", 64'(mem_we), 64'(0));
    chk("done_busy", 64'(busy), 64'(1));
    chk("done_stall", 64'(fetch_stall), 64'(hold));
    chk("write_count", 64'(wcount - wbefore), 64'(n));
    tick();
    load_valid = 1'b0;
    chk("post_done", 64'(load_done), 64'(0));
    chk("post_busy", 64'(busy), 64'(0));
    if (hold) begin
      chk("post_fetch_valid0", 64'(fetch_valid), 64'(0));
      tick();
      fetch_req = 1'b0;
      chk("resume_valid", 64'(fetch_valid), 64'(1));
      chk("resume_instr", 64'(fetch_instr), 64'(ref_mem[fa]));
    end
    fetch_req = 1'b0;
  endtask

  initial begin
    int wb;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = NOP;
      ref_mem[i] = NOP;
    end
    #12;
    chk("rst_fetch_valid", 64'(fetch_valid), 64'(0));
    chk("rst_fetch_instr", 64'(fetch_instr), 64'(0));
    chk("rst_load_done", 64'(load_done), 64'(0));
    chk("rst_load_ready", 64'(load_ready), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    tick();

    fetch_chk(10'h000, "nop_fetch");

    // load_valid in RUN must not write
    load_valid = 1'b1;
    wb = wcount;
    #1;
    chk("run_valid_we", 64'(mem_we), 64'(0));
    tick();
    load_valid = 1'b0;
    chk("run_valid_count", 64'(wcount - wb), 64'(0));

    do_load(10'h010, 11'd3, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) fetch_chk(10'h010 + 10'(i), "seq_fetch");

    do_load(10'h3FE, 11'd4, 0, 1'b0, 1'b0);
    fetch_chk(10'h3FE, "wrap0");
    fetch_chk(10'h3FF, "wrap1");
    fetch_chk(10'h000, "wrap2");
    fetch_chk(10'h001, "wrap3");

    do_load(10'h080, 11'd6, 1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) fetch_chk(10'h080 + 10'(i), "gap_fetch");

    do_load(10'h055, 11'd0, 0, 1'b1, 1'b0);
    do_load(ADDR_W'($urandom), 11'd2000, 0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) fetch_chk(ADDR_W'($urandom), "clamp_fetch");

    for (int r = 0; r < 5; r++) begin
      logic [ADDR_W-1:0] b;
      logic [ADDR_W:0]   l;
      b = ADDR_W'($urandom);
      l = (ADDR_W+1)'($urandom_range(0, 12));
      do_load(b, l, 2, 1'($urandom_range(0, 1)), 1'b0);
      for (int i = 0; i < int'(l); i++) fetch_chk(b + ADDR_W'(i), "rnd_fetch");
      fetch_chk(ADDR_W'($urandom), "rnd_other");
    end

    // reset after 2 of 5 words
    load_start = 1'b1;
    load_base  = 10'h200;
    load_len   = 11'd5;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = INSTR_W'({$urandom(), $urandom()});
      ref_mem[10'h200 + 10'(i)] = load_data;
      tick();
    end
    load_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(load_done), 64'(0));
    chk("mid_rst_ready", 64'(load_ready), 64'(0));
    #1;
    rst_n = 1'b1;
    tick();
    chk("after_rst_busy", 64'(busy), 64'(0));
    chk("after_rst_done", 64'(load_done), 64'(0));
    for (int i = 0; i < 5; i++) fetch_chk(10'h200 + 10'(i), "rst_fetch");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
